// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bundle between the EX stage and the MIPS multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             flush_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, a_i, b_i, flush_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i,
    output busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one 33-bit add/sub per iteration.
// Optional zero-operand shortcut enabled by defining MULDIV_EARLY_OUT_EN.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;    // product high half / partial remainder
  logic [WIDTH-1:0] shr_q, shr_d;    // multiplier (shifts out) / quotient (shifts in)
  logic [WIDTH-1:0] opnd_q, opnd_d;  // multiplicand / divisor magnitude
  logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic             is_div, is_signed, b_zero;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   add_x, add_y;
  logic             add_sub;
  logic [WIDTH+1:0] add_res;
  logic [WIDTH:0]   mul_t;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign b_zero    = (b_q == '0);
  assign abs_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign abs_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

  // Shared 33-bit adder: add for MUL, subtract (~b, cin=1) for DIV; bit WIDTH+1 is the no-borrow flag.
  assign add_sub = is_div;
  assign add_x   = is_div ? {acc_q, shr_q[WIDTH-1]} : {1'b0, acc_q};
  assign add_y   = {1'b0, opnd_q};
  assign add_res = {1'b0, add_x} + {1'b0, add_y ^ {(WIDTH+1){add_sub}}}
                 + {{(WIDTH+1){1'b0}}, add_sub};

  assign mul_t    = shr_q[0] ? add_res[WIDTH:0] : {1'b0, acc_q};
  assign prod     = {acc_q, shr_q};
  assign prod_fix = neg_res_q ? -prod : prod;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    shr_d     = shr_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          op_d    = bus.op_i;
          a_d     = bus.a_i;
          b_d     = bus.b_i;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        neg_res_d = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_rem_d = is_signed & a_q[WIDTH-1];
        acc_d     = '0;
        shr_d     = is_div ? abs_a : abs_b;
        opnd_d    = is_div ? abs_b : abs_a;
        cnt_d     = '0;
        state_d   = S_RUN;
`ifdef MULDIV_EARLY_OUT_EN
        // Zero operand: clear the working product/quotient so FIX yields the same result as a full run.
        if (a_q == '0 || b_zero) begin
          shr_d   = '0;
          state_d = S_FIX;
        end
`endif
      end
      S_RUN: begin
        if (is_div) begin
          acc_d = add_res[WIDTH+1] ? add_res[WIDTH-1:0] : add_x[WIDTH-1:0];
          shr_d = {shr_q[WIDTH-2:0], add_res[WIDTH+1]};
        end else begin
          acc_d = mul_t[WIDTH:1];
          shr_d = {mul_t[0], shr_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!is_div) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (b_zero) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = neg_rem_q ? -acc_q : acc_q;
          lo_d = neg_res_q ? -shr_q : shr_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A squash abandons the operation, including a pending HI/LO write in FIX.
    if (bus.flush_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      shr_q     <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      shr_q     <= shr_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy_o = (state_q != S_IDLE);
  assign bus.done_o = done_q;
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: results, latency, busy, flush, reset and back-to-back starts.
module tb_muldiv_sequencer;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 34;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   lat, busy_cnt, done_cnt;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a request for one cycle; returns #1 after the accepting edge E0.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  // Counts edges after E0 until done_o is seen; lat stays -1 if the budget expires.
  task automatic wait_done(output int l, output int bc);
    l  = -1;
    bc = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (bus.done_o) begin
        l = k;
        break;
      end
      if (bus.busy_o) bc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int l, bc;
    start_op(op, a, b);
    wait_done(l, bc);
    check({tag, "_lat"}, 64'(l), 64'(exp_lat));
    check({tag, "_hi"}, 64'(bus.hi_o), 64'(exp_hi));
    check({tag, "_lo"}, 64'(bus.lo_o), 64'(exp_lo));
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.op_i    = 2'b00;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.flush_i = 1'b0;

    #12;
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_done", 64'(bus.done_o), 64'd0);
    check("rst_hi", 64'(bus.hi_o), 64'd0);
    check("rst_lo", 64'(bus.lo_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // MULTU max*max with latency, busy window and single-cycle done pulse.
    start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_busy_e0", 64'(bus.busy_o), 64'd1);
    wait_done(lat, busy_cnt);
    check("multu_lat", 64'(lat), 64'd34);
    check("multu_busy_at_done", 64'(bus.busy_o), 64'd0);
    check("multu_hi", 64'(bus.hi_o), 64'hFFFF_FFFE);
    check("multu_lo", 64'(bus.lo_o), 64'h0000_0001);
    @(posedge clk);
    #1;
    check("multu_done_pulse", 64'(bus.done_o), 64'd0);

    start_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done(lat, busy_cnt);
    check("mult_busy_cycles", 64'(busy_cnt), 64'd33);
    check("mult_hi", 64'(bus.hi_o), 64'hFFFF_FFFF);
    check("mult_lo", 64'(bus.lo_o), 64'hFFFF_FFEB);

    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_by0", OP_DIVU, 32'd7, 32'd0, EARLY_LAT, 32'd7, 32'hFFFF_FFFF);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000);

    // Flush at RUN count 10 (the cycle after E11): nothing written, busy drops next cycle.
    start_op(OP_MULTU, 32'd3, 32'd5);
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      #1;
    end
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    check("flush_busy", 64'(bus.busy_o), 64'd0);
    check("flush_done", 64'(bus.done_o), 64'd0);
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done_o) done_cnt++;
    end
    check("flush_no_done", 64'(done_cnt), 64'd0);
    check("flush_hi", 64'(bus.hi_o), 64'h0);
    check("flush_lo", 64'(bus.lo_o), 64'h8000_0000);

    // Flush and start together in IDLE: the start is dropped.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.flush_i = 1'b1;
    bus.op_i    = OP_MULTU;
    bus.a_i     = 32'd9;
    bus.b_i     = 32'd9;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    check("flush_start_busy", 64'(bus.busy_o), 64'd0);

    // Back-to-back: second start issued in the done cycle of the first.
    run_op("divu_8_2", OP_DIVU, 32'd8, 32'd2, 34, 32'd0, 32'd4);
    run_op("divu_b2b", OP_DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14);

    // A start while busy is ignored; HI/LO hold mid-operation.
    start_op(OP_MULTU, 32'd6, 32'd7);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      bus.start_i = (k == 5);
      if (k == 5) begin
        bus.op_i = OP_DIV;
        bus.a_i  = 32'd1;
        bus.b_i  = 32'd1;
        check("busy_hold_hi", 64'(bus.hi_o), 64'd2);
        check("busy_hold_lo", 64'(bus.lo_o), 64'd14);
      end
      if (bus.done_o) begin
        lat = k;
        break;
      end
    end
    bus.start_i = 1'b0;
    check("ignore_start_lat", 64'(lat), 64'd34);
    check("ignore_start_lo", 64'(bus.lo_o), 64'd42);

    // Flush during FIX (the cycle after E33) suppresses the write.
    start_op(OP_DIV, 32'd100, 32'hFFFF_FFF9);
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk);
      #1;
    end
    check("fix_busy", 64'(bus.busy_o), 64'd1);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    check("fix_flush_done", 64'(bus.done_o), 64'd0);
    check("fix_flush_hi", 64'(bus.hi_o), 64'd0);
    check("fix_flush_lo", 64'(bus.lo_o), 64'd42);

    // Asynchronous reset mid-RUN, then a normal operation.
    start_op(OP_MULTU, 32'd3, 32'd5);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(bus.busy_o), 64'd0);
    check("arst_lo", 64'(bus.lo_o), 64'd0);
    check("arst_done", 64'(bus.done_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", OP_MULTU, 32'd3, 32'd5, 34, 32'd0, 32'd15);

    // Zero-operand cases: results match a full run, latency depends on the build.
    run_op("mult_zero", OP_MULT, 32'd0, 32'd5, EARLY_LAT, 32'd0, 32'd0);
    run_op("div_by0_neg", OP_DIV, 32'hFFFF_FFF7, 32'd0, EARLY_LAT, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
    run_op("div_zero", OP_DIV, 32'd0, 32'hFFFF_FFFD, EARLY_LAT, 32'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
